// File: rtl/ir_encoder.sv
// ir_encoder: pulse-distance IR transmitter for the link to ir_decoder.
// Accepts a MESSAGE_LENGTH-bit letter code over valid/ready and sends it as
// leader mark/space, MSB-first data bits, a stop mark and an inter-frame gap.
// Optional macro IR_CARRIER_EN: when defined, marks are modulated by a
// square-wave carrier toggling every CARRIER_HALF cycles; when undefined,
// signal_out carries the bare envelope for wired loopback.
module ir_encoder #(
    parameter int MESSAGE_LENGTH = 5,
    parameter int UNIT_CYCLES    = 56250,
`ifdef IR_CARRIER_EN
    parameter int CARRIER_HALF   = 1316,
`endif
    parameter int GAP_UNITS      = 32
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      data_valid_in,
    input  logic [MESSAGE_LENGTH-1:0] code_in,
    output logic                      ready_out,
    output logic                      signal_out,
    output logic                      done_out,
    output logic [2:0]                state_out
);

    // Timer, unit-count and bit-count widths.
    localparam int UW      = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int LONGEST = (GAP_UNITS > 16) ? GAP_UNITS : 16;
    localparam int NW_RAW  = $clog2(LONGEST + 1);
    localparam int NW      = (NW_RAW > 6) ? NW_RAW : 6;
    localparam int BW      = $clog2(MESSAGE_LENGTH + 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LEAD_MARK  = 3'd1;
    localparam logic [2:0] S_LEAD_SPACE = 3'd2;
    localparam logic [2:0] S_BIT_MARK   = 3'd3;
    localparam logic [2:0] S_BIT_SPACE  = 3'd4;
    localparam logic [2:0] S_STOP_MARK  = 3'd5;
    localparam logic [2:0] S_GAP        = 3'd6;

    logic [2:0]                state_q, state_d;
    logic [UW-1:0]             unit_q, unit_d;
    logic [NW-1:0]             units_q, units_d;
    logic [BW-1:0]             bits_q, bits_d;
    logic [MESSAGE_LENGTH-1:0] shift_q, shift_d;
    logic                      sig_q, sig_d;
    logic                      unit_tick;
    logic                      state_last;
    logic [NW-1:0]             span;
    logic                      mark_d;

    // Next-state logic: unit timer, per-state unit count and frame sequencing.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        shift_d    = shift_q;
        bits_d     = bits_q;
        span       = NW'(1);
        unit_tick  = (state_q != S_IDLE) && (unit_q == UW'(UNIT_CYCLES - 1));

        case (state_q)
            S_LEAD_MARK:  span = NW'(16);
            S_LEAD_SPACE: span = NW'(8);
            S_BIT_SPACE:  span = shift_q[MESSAGE_LENGTH-1] ? NW'(3) : NW'(1);
            S_GAP:        span = NW'(GAP_UNITS);
            default:      span = NW'(1);
        endcase

        state_last = unit_tick && (units_q == span - NW'(1));

        if (state_q == S_IDLE || unit_tick) unit_d = '0;
        else                                unit_d = unit_q + UW'(1);

        if (state_q == S_IDLE || state_last) units_d = '0;
        else if (unit_tick)                  units_d = units_q + NW'(1);
        else                                 units_d = units_q;

        case (state_q)
            S_IDLE: begin
                // ready_out is high throughout IDLE, so valid alone completes the handshake.
                if (data_valid_in) begin
                    state_d = S_LEAD_MARK;
                    shift_d = code_in;
                    bits_d  = '0;
                end
            end
            S_LEAD_MARK:  if (state_last) state_d = S_LEAD_SPACE;
            S_LEAD_SPACE: if (state_last) state_d = S_BIT_MARK;
            S_BIT_MARK:   if (state_last) state_d = S_BIT_SPACE;
            S_BIT_SPACE: begin
                if (state_last) begin
                    shift_d = shift_q << 1;
                    bits_d  = bits_q + BW'(1);
                    state_d = (bits_q == BW'(MESSAGE_LENGTH - 1)) ? S_STOP_MARK : S_BIT_MARK;
                end
            end
            S_STOP_MARK:  if (state_last) state_d = S_GAP;
            S_GAP:        if (state_last) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase

        mark_d = (state_d == S_LEAD_MARK) || (state_d == S_BIT_MARK) ||
                 (state_d == S_STOP_MARK);
    end

`ifdef IR_CARRIER_EN
    localparam int CHW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

    logic [CHW-1:0] car_cnt_q, car_cnt_d;
    logic           car_q, car_d;

    // Carrier phase: restarts high at each mark entry, held in reset during spaces.
    always_comb begin
        car_cnt_d = car_cnt_q + CHW'(1);
        car_d     = car_q;
        if (!mark_d || (state_d != state_q)) begin
            car_cnt_d = '0;
            car_d     = 1'b1;
        end else if (car_cnt_q == CHW'(CARRIER_HALF - 1)) begin
            car_cnt_d = '0;
            car_d     = ~car_q;
        end
        sig_d = mark_d & car_d;
    end

    // Carrier registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            car_cnt_q <= '0;
            car_q     <= 1'b1;
        end else begin
            car_cnt_q <= car_cnt_d;
            car_q     <= car_d;
        end
    end
`else
    // Unmodulated envelope for direct loopback into ir_decoder.
    always_comb sig_d = mark_d;
`endif

    // State registers with synchronous reset; the LED output is registered so it never glitches.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_in) begin
            state_q <= S_IDLE;
            unit_q  <= '0;
            units_q <= '0;
            bits_q  <= '0;
            shift_q <= '0;
            sig_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            unit_q  <= unit_d;
            units_q <= units_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            sig_q   <= sig_d;
        end
    end

    // done_out marks the final GAP cycle, so it can never share a cycle with an acceptance.
    assign done_out   = (state_q == S_GAP) && state_last;
    assign ready_out  = (state_q == S_IDLE);
    assign signal_out = sig_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_ir_encoder.sv
// tb_ir_encoder: directed and randomized frames compared cycle by cycle
// against a waveform built from the frame rules (leader, bits, stop, gap).
module tb_ir_encoder;

    localparam int ML  = 5;
    localparam int U   = 4;
    localparam int GAP = 4;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          data_valid_in;
    logic [ML-1:0] code_in;
    logic          ready_out;
    logic          signal_out;
    logic          done_out;
    logic [2:0]    state_out;

    int checks   = 0;
    int failures = 0;
    bit exp_q[$];

    ir_encoder #(
        .MESSAGE_LENGTH(ML),
        .UNIT_CYCLES   (U),
        .GAP_UNITS     (GAP)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .data_valid_in(data_valid_in),
        .code_in      (code_in),
        .ready_out    (ready_out),
        .signal_out   (signal_out),
        .done_out     (done_out),
        .state_out    (state_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input bit level, input int units);
        repeat (units * U) exp_q.push_back(level);
    endtask

    // Expected LED level for each cycle of a frame, from the first high cycle to done.
    task automatic build_wave(input logic [ML-1:0] code);
        logic [ML-1:0] c;
        c = code;
        exp_q.delete();
        push(1'b1, 16);
        push(1'b0, 8);
        for (int b = ML - 1; b >= 0; b--) begin
            push(1'b1, 1);
            push(1'b0, c[b] ? 3 : 1);
        end
        push(1'b1, 1);
        push(1'b0, GAP);
    endtask

    // Accept one code and follow the whole frame; optionally pulse a stray valid at noise_idx.
    task automatic run_frame(input logic [ML-1:0] code, input int noise_idx, input bit keep_valid);
        int len;
        build_wave(code);
        len = exp_q.size();
        data_valid_in = 1'b1;
        code_in       = code;
        check("ready_idle", 32'(ready_out), 32'd1);
        check("state_idle", 32'(state_out), 32'd0);
        tick();
        data_valid_in = keep_valid;
        code_in       = ML'($urandom);
        check("state_lead", 32'(state_out), 32'd1);
        for (int i = 0; i < len; i++) begin
            check("sig", 32'(signal_out), 32'(exp_q[i]));
            check("done", 32'(done_out), 32'(i == len - 1));
            check("ready_busy", 32'(ready_out), 32'd0);
            if (i == noise_idx) begin
                data_valid_in = 1'b1;
                code_in       = 5'd3;
            end else if (i == noise_idx + 1) begin
                data_valid_in = keep_valid;
            end
            tick();
        end
        check("ready_after", 32'(ready_out), 32'd1);
        check("state_after", 32'(state_out), 32'd0);
        check("done_after", 32'(done_out), 32'd0);
        check("sig_after", 32'(signal_out), 32'd0);
    endtask

    // Start a frame, abort it with rst_in after k cycles, and confirm a clean, silent abort.
    task automatic reset_mid(input logic [ML-1:0] code, input int k, input logic [2:0] exp_state);
        data_valid_in = 1'b1;
        code_in       = code;
        tick();
        data_valid_in = 1'b0;
        repeat (k) tick();
        check("pre_rst_state", 32'(state_out), 32'(exp_state));
        check("pre_rst_sig", 32'(signal_out), 32'd1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("rst_sig", 32'(signal_out), 32'd0);
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_done", 32'(done_out), 32'd0);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("post_rst_done", 32'(done_out), 32'd0);
            check("post_rst_sig", 32'(signal_out), 32'd0);
        end
    endtask

    initial begin
        rst_in        = 1'b1;
        data_valid_in = 1'b0;
        code_in       = '0;
        repeat (3) tick();
        check("reset_sig", 32'(signal_out), 32'd0);
        check("reset_ready", 32'(ready_out), 32'd1);
        check("reset_done", 32'(done_out), 32'd0);
        check("reset_state", 32'(state_out), 32'd0);
        rst_in = 1'b0;
        tick();
        check("idle_sig", 32'(signal_out), 32'd0);

        // Basic frame.
        run_frame(5'b10110, -1, 1'b0);
        repeat (3) tick();

        // Stray valid with code 3 during the first BIT_SPACE of a 25 frame.
        run_frame(5'd25, 25 * U + 1, 1'b0);

        // Back-to-back with valid held high.
        run_frame(5'd0, -1, 1'b1);
        run_frame(5'd25, -1, 1'b0);

        // Mid-frame resets in LEAD_MARK and BIT_MARK, then a clean frame.
        reset_mid(5'd9, 10, 3'd1);
        reset_mid(5'd9, 24 * U + 1, 3'd3);
        run_frame(5'd7, -1, 1'b0);

        // Code boundaries.
        run_frame(5'd0, -1, 1'b0);
        run_frame(5'd31, -1, 1'b0);

        // Randomized codes, idle gaps and stray valids.
        for (int n = 0; n < 6; n++) begin
            logic [ML-1:0] c;
            int            noise;
            c = ML'($urandom_range(0, 31));
            noise = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 150)) : -1;
            repeat ($urandom_range(0, 3)) tick();
            run_frame(c, noise, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
